// File: rtl/opl3_pkg.sv
`default_nettype none
// ============================================================================
// Package     : opl3_pkg
// Description : Shared constants and types for the OPL3 operator
//               scheduler: register-write strobe, operator result stream
//               and scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package opl3_pkg;

  localparam int NUM_BANKS              = 2;
  localparam int NUM_OPERATORS_PER_BANK = 18;
  localparam int BANK_NUM_WIDTH         = 1;
  localparam int OP_NUM_WIDTH           = 5;
  localparam int REG_ADDR_WIDTH         = 8;
  localparam int REG_DATA_WIDTH         = 8;
  localparam int OP_OUT_WIDTH           = 13;
  localparam int CLK_DIV_COUNT          = 256;
  localparam int OP_SLOT_CYCLES         = 6;
  localparam int NUM_OP_SLOTS           = NUM_BANKS * NUM_OPERATORS_PER_BANK;

  // Register-file write: one bank-qualified address/data pair.
  typedef struct packed {
    logic                      valid;
    logic [BANK_NUM_WIDTH-1:0] bank_num;
    logic [REG_ADDR_WIDTH-1:0] address;
    logic [REG_DATA_WIDTH-1:0] data;
  } opl3_reg_wr_t;

  // One result from the shared operator pipeline.
  typedef struct packed {
    logic                      valid;
    logic [BANK_NUM_WIDTH-1:0] bank_num;
    logic [OP_NUM_WIDTH-1:0]   op_num;
    logic [OP_OUT_WIDTH-1:0]   level;
  } operator_out_t;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_RUN   = 2'd1,
    SCHED_DRAIN = 2'd2
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/opl3_reg_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : opl3_reg_wr_fifo
// Description : Small synchronous FIFO buffering host register writes until
//               the scheduler can commit them between frames. Pointers carry
//               one extra wrap bit so full and empty are distinguishable.
// Revision    : 1.0 - initial release
// ============================================================================
module opl3_reg_wr_fifo
  import opl3_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  opl3_reg_wr_t data_i,
  input  logic         pop_i,
  output opl3_reg_wr_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_q;
  logic [PTR_W:0] rd_ptr_q;
  opl3_reg_wr_t   mem_q [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Advance read/write pointers; wrap bit toggles naturally on overflow.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // Payload storage needs no reset; emptiness is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/opl3_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : opl3_op_scheduler
// Description : Per-sample time-slot scheduler for the shared OPL3 operator
//               pipeline. Issues 36 operator slots per sample tick, waits for
//               the final result, and commits buffered host register writes
//               only while idle so a frame sees one consistent register set.
// Revision    : 1.0 - initial release
// ============================================================================
module opl3_op_scheduler
  import opl3_pkg::*;
#(
  parameter int SLOT_CYCLES   = OP_SLOT_CYCLES,
  parameter int WR_FIFO_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      sample_clk_en_i,
  input  opl3_reg_wr_t              host_wr_i,
  output logic                      host_wr_ready_o,
  output opl3_reg_wr_t              reg_wr_o,
  output logic                      op_start_o,
  output logic [BANK_NUM_WIDTH-1:0] bank_num_o,
  output logic [OP_NUM_WIDTH-1:0]   op_num_o,
  input  operator_out_t             op_out_i,
  output logic                      sample_done_o,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int CYC_W  = $clog2(SLOT_CYCLES);
  localparam int SLOT_W = $clog2(NUM_OP_SLOTS);

  localparam logic [CYC_W-1:0]          CYC_LAST  = CYC_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0]         SLOT_LAST = SLOT_W'(NUM_OP_SLOTS - 1);
  localparam logic [OP_NUM_WIDTH-1:0]   OP_LAST   = OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK - 1);
  localparam logic [BANK_NUM_WIDTH-1:0] BANK_LAST = BANK_NUM_WIDTH'(NUM_BANKS - 1);

  sched_state_t                state_q;
  logic [CYC_W-1:0]            cyc_q;
  logic [SLOT_W-1:0]           slot_q;
  logic [BANK_NUM_WIDTH-1:0]   bank_q;
  logic [OP_NUM_WIDTH-1:0]     op_q;
  logic                        op_start_q;
  logic                        sample_done_q;
  logic                        busy_q;
  logic                        overrun_q;
  opl3_reg_wr_t                reg_wr_q;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  opl3_reg_wr_t                fifo_data;
  logic                        last_result;
  logic                        unused_bits;

  opl3_reg_wr_fifo #(
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (host_wr_i.valid),
    .data_i  (host_wr_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A frame start wins over a commit in the same idle cycle.
  assign fifo_pop    = (state_q == SCHED_IDLE) && !sample_clk_en_i && !fifo_empty;
  assign last_result = op_out_i.valid &&
                       (op_out_i.bank_num == BANK_LAST) &&
                       (op_out_i.op_num == OP_LAST);
  assign unused_bits = ^{op_out_i.level, fifo_data.valid};

  assign host_wr_ready_o = !fifo_full;
  assign reg_wr_o        = reg_wr_q;
  assign op_start_o      = op_start_q;
  assign bank_num_o      = bank_q;
  assign op_num_o        = op_q;
  assign sample_done_o   = sample_done_q;
  assign busy_o          = busy_q;
  assign overrun_o       = overrun_q;

  // Frame FSM with slot/cycle counters; all outputs registered alongside state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= SCHED_IDLE;
      cyc_q         <= '0;
      slot_q        <= '0;
      bank_q        <= '0;
      op_q          <= '0;
      op_start_q    <= 1'b0;
      sample_done_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      op_start_q    <= 1'b0;
      sample_done_q <= 1'b0;
      if (sample_clk_en_i && (state_q != SCHED_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        SCHED_IDLE: begin
          if (sample_clk_en_i) begin
            state_q    <= SCHED_RUN;
            busy_q     <= 1'b1;
            cyc_q      <= '0;
            slot_q     <= '0;
            bank_q     <= '0;
            op_q       <= '0;
            op_start_q <= 1'b1;
          end
        end
        SCHED_RUN: begin
          if (cyc_q == CYC_LAST) begin
            cyc_q <= '0;
            if (slot_q == SLOT_LAST) begin
              state_q <= SCHED_DRAIN;
              slot_q  <= '0;
              bank_q  <= '0;
              op_q    <= '0;
            end else begin
              slot_q     <= slot_q + SLOT_W'(1);
              op_start_q <= 1'b1;
              if (op_q == OP_LAST) begin
                op_q   <= '0;
                bank_q <= bank_q + BANK_NUM_WIDTH'(1);
              end else begin
                op_q <= op_q + OP_NUM_WIDTH'(1);
              end
            end
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        SCHED_DRAIN: begin
          if (last_result) begin
            state_q       <= SCHED_IDLE;
            busy_q        <= 1'b0;
            sample_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= SCHED_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Register-file strobe: one committed FIFO entry per pop, otherwise all zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      reg_wr_q <= '0;
    end else if (fifo_pop) begin
      reg_wr_q.valid    <= 1'b1;
      reg_wr_q.bank_num <= fifo_data.bank_num;
      reg_wr_q.address  <= fifo_data.address;
      reg_wr_q.data     <= fifo_data.data;
    end else begin
      reg_wr_q <= '0;
    end
  end

endmodule
`default_nettype wire
